// File: rtl/piano_pkg.sv
// Shared constants, types and the note half-period table for the piano tone path.
package piano_pkg;

    localparam int unsigned NUM_KEYS    = 8;
    localparam int unsigned DEB_SAMPLES = 4;
    localparam int unsigned HP_WIDTH    = 11;
    localparam int unsigned IDX_WIDTH   = 3;

    typedef logic [HP_WIDTH-1:0]  half_period_t;
    typedef logic [IDX_WIDTH-1:0] note_idx_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } tone_state_t;

    // Half-periods in 1 us strobes, index 0 = C4 ... index 7 = C5
    localparam half_period_t HALF_PERIOD [NUM_KEYS] = '{
        11'd1911, 11'd1703, 11'd1517, 11'd1432,
        11'd1276, 11'd1136, 11'd1012, 11'd956
    };

    function automatic half_period_t half_period_of(input note_idx_t idx);
        return HALF_PERIOD[idx];
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One piano key: 2-flop synchronizer, sample history on the 250 Hz strobe, debounced state.
module key_debounce
    import piano_pkg::*;
(
    input  logic clk_100M,
    input  logic rst,
    input  logic clk_250,
    input  logic key,
    output logic deb
);

    logic                   sync_meta;
    logic                   sync_q;
    logic [DEB_SAMPLES-1:0] hist;
    logic [DEB_SAMPLES-1:0] hist_next;

    assign hist_next = {hist[DEB_SAMPLES-2:0], sync_q};

    // Bring the asynchronous key into the clk_100M domain
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= key;
            sync_q    <= sync_meta;
        end
    end

    // Shift a sample per strobe; change state only on a run of identical samples
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            hist <= '0;
            deb  <= 1'b0;
        end else if (clk_250) begin
            hist <= hist_next;
            if (&hist_next) begin
                deb <= 1'b1;
            end else if (~|hist_next) begin
                deb <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/note_synth.sv
// Keyboard-to-tone stage: debounce eight keys, pick the highest, emit its square wave.
module note_synth
    import piano_pkg::*;
(
    input  logic                 clk_100M,
    input  logic                 rst,
    input  logic                 clk_250,
    input  logic                 clk_1M,
    input  logic [NUM_KEYS-1:0]  keys,
    output logic                 audio_out,
    output logic                 note_valid,
    output logic [IDX_WIDTH-1:0] note_idx
);

    logic [NUM_KEYS-1:0] deb_keys;
    logic                sel_valid;
    note_idx_t           sel_idx;

    tone_state_t  state;
    tone_state_t  state_next;
    half_period_t half_cnt;
    half_period_t cur_half;
    note_idx_t    cur_idx;

    logic         audio_d;
    logic         valid_d;
    half_period_t cnt_d;
    half_period_t half_d;
    note_idx_t    idx_d;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce u_deb (
            .clk_100M (clk_100M),
            .rst      (rst),
            .clk_250  (clk_250),
            .key      (keys[k]),
            .deb      (deb_keys[k])
        );
    end

    // Highest debounced key wins (C5 has top priority)
    always_comb begin
        sel_valid = |deb_keys;
        sel_idx   = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (deb_keys[i]) begin
                sel_idx = IDX_WIDTH'(i);
            end
        end
    end

    // Tone state register
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Tone next-state: start on any key, stop as soon as no key is held
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (sel_valid)  state_next = ST_PLAY;
            ST_PLAY: if (!sel_valid) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Tone outputs: note changes only at a half-period boundary; release beats a due toggle
    always_comb begin
        audio_d = audio_out;
        valid_d = note_valid;
        cnt_d   = half_cnt;
        half_d  = cur_half;
        idx_d   = cur_idx;
        case (state)
            ST_IDLE: begin
                audio_d = 1'b0;
                valid_d = 1'b0;
                cnt_d   = '0;
                if (sel_valid) begin
                    idx_d   = sel_idx;
                    half_d  = half_period_of(sel_idx);
                    audio_d = 1'b1;
                    valid_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (!sel_valid) begin
                    audio_d = 1'b0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end else if (clk_1M) begin
                    if (half_cnt == cur_half - HP_WIDTH'(1)) begin
                        cnt_d   = '0;
                        audio_d = ~audio_out;
                        idx_d   = sel_idx;
                        half_d  = half_period_of(sel_idx);
                    end else begin
                        cnt_d = half_cnt + HP_WIDTH'(1);
                    end
                end
            end
            default: begin
                audio_d = 1'b0;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // Tone datapath registers
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            audio_out  <= 1'b0;
            note_valid <= 1'b0;
            half_cnt   <= '0;
            cur_half   <= '0;
            cur_idx    <= '0;
        end else begin
            audio_out  <= audio_d;
            note_valid <= valid_d;
            half_cnt   <= cnt_d;
            cur_half   <= half_d;
            cur_idx    <= idx_d;
        end
    end

    assign note_idx = cur_idx;

endmodule
